// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the data-memory access controller.
package mem_ctrl_pkg;

   localparam int MEM_DW            = 32;
   localparam int MEM_AW            = 32;
   localparam int MAX_ACCESS_CYCLES = 15;
   localparam int CNT_W             = 4;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SETUP  = 3'd1,
      STROBE = 3'd2,
      HOLD   = 3'd3,
      ERR    = 3'd4
   } state_e;

   function automatic logic is_word_aligned(input logic [MEM_AW-1:0] addr);
      return (addr[1:0] == 2'b00);
   endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Loadable 4-bit down-counter that times how long a memory strobe stays high.
module mem_wait_counter
   import mem_ctrl_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             dec,
   input  logic [CNT_W-1:0] load_val,
   output logic             zero
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // Next count: load wins over decrement; saturate at zero.
   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (dec && (count_q != {CNT_W{1'b0}})) begin
         count_d = count_q - {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         count_d = count_q;
      end
   end

   // Count register.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= {CNT_W{1'b0}};
      end else begin
         count_q <= count_d;
      end
   end

   assign zero = (count_q == {CNT_W{1'b0}});

endmodule

// File: rtl/mem_access_ctrl.sv
// Initiator-side sequencer for single-word loads/stores toward MEM:
// SETUP -> STROBE (ACCESS_CYCLES) -> HOLD, with misaligned requests short-cut to ERR.
module mem_access_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int ACCESS_CYCLES = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   input  logic              req_write,
   input  logic [MEM_AW-1:0] req_addr,
   input  logic [MEM_DW-1:0] req_wdata,
   output logic              req_ready,
   output logic              resp_valid,
   output logic              resp_err,
   output logic [MEM_DW-1:0] resp_rdata,
   output logic              MemRead,
   output logic              memWrite,
   output logic [MEM_AW-1:0] Address,
   output logic [MEM_DW-1:0] write_data,
   input  logic [MEM_DW-1:0] read_data
);

   localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(ACCESS_CYCLES - 1);

   state_e            state_q, state_d;
   logic              wr_q, wr_d;
   logic [MEM_AW-1:0] addr_q, addr_d;
   logic [MEM_DW-1:0] wdata_q, wdata_d;
   logic              mem_read_q, mem_read_d;
   logic              mem_write_q, mem_write_d;
   logic              resp_valid_q, resp_valid_d;
   logic              resp_err_q, resp_err_d;
   logic [MEM_DW-1:0] resp_rdata_q, resp_rdata_d;
   logic              cnt_load_s, cnt_dec_s, cnt_zero_s;

   mem_wait_counter u_wait_counter (
      .clk      (clk),
      .rst      (rst),
      .load     (cnt_load_s),
      .dec      (cnt_dec_s),
      .load_val (LOAD_VAL),
      .zero     (cnt_zero_s)
   );

   assign req_ready = (state_q == IDLE) && !rst;

   // Next state and next registered outputs; strobes are computed one cycle
   // ahead so they rise on STROBE entry and fall on STROBE exit.
   always_comb begin
      state_d      = state_q;
      wr_d         = wr_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      mem_read_d   = 1'b0;
      mem_write_d  = 1'b0;
      resp_valid_d = 1'b0;
      resp_err_d   = 1'b0;
      resp_rdata_d = {MEM_DW{1'b0}};
      cnt_load_s   = 1'b0;
      cnt_dec_s    = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_valid && req_ready) begin
               if (is_word_aligned(req_addr)) begin
                  wr_d    = req_write;
                  addr_d  = req_addr;
                  wdata_d = req_wdata;
                  state_d = SETUP;
               end else begin
                  resp_valid_d = 1'b1;
                  resp_err_d   = 1'b1;
                  state_d      = ERR;
               end
            end else begin
               state_d = IDLE;
            end
         end
         SETUP: begin
            cnt_load_s  = 1'b1;
            mem_read_d  = !wr_q;
            mem_write_d = wr_q;
            state_d     = STROBE;
         end
         STROBE: begin
            if (cnt_zero_s) begin
               resp_valid_d = 1'b1;
               resp_rdata_d = wr_q ? {MEM_DW{1'b0}} : read_data;
               state_d      = HOLD;
            end else begin
               cnt_dec_s   = 1'b1;
               mem_read_d  = !wr_q;
               mem_write_d = wr_q;
               state_d     = STROBE;
            end
         end
         HOLD:    state_d = IDLE;
         ERR:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State, request latches and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         wr_q         <= 1'b0;
         addr_q       <= {MEM_AW{1'b0}};
         wdata_q      <= {MEM_DW{1'b0}};
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= {MEM_DW{1'b0}};
      end else begin
         state_q      <= state_d;
         wr_q         <= wr_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         mem_read_q   <= mem_read_d;
         mem_write_q  <= mem_write_d;
         resp_valid_q <= resp_valid_d;
         resp_err_q   <= resp_err_d;
         resp_rdata_q <= resp_rdata_d;
      end
   end

   assign MemRead    = mem_read_q;
   assign memWrite   = mem_write_q;
   assign Address    = addr_q;
   assign write_data = wdata_q;
   assign resp_valid = resp_valid_q;
   assign resp_err   = resp_err_q;
   assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: two instances (ACCESS_CYCLES 1 and 3), each with a
// MEM model and a timeline-based reference model compared on every cycle.
module tb_mem_access_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   int vectors = 0;
   int miscompares = 0;
   bit cmp_en = 1'b0;

   logic        req_valid_a [2];
   logic        req_write_a [2];
   logic [31:0] req_addr_a  [2];
   logic [31:0] req_wdata_a [2];
   logic        ready_a     [2];
   logic        resp_valid_a[2];
   logic        resp_err_a  [2];
   logic [31:0] resp_rdata_a[2];
   logic        mem_read_a  [2];
   logic        mem_write_a [2];
   logic [31:0] address_a   [2];
   logic [31:0] write_data_a[2];
   logic [31:0] read_data_a [2];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rst) cmp_en <= 1'b1;
   end

   function automatic logic [31:0] init_word(input logic [5:0] idx);
      return (idx == 6'd4) ? 32'hCAFEF00D : 32'h0;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   for (genvar gi = 0; gi < 2; gi++) begin : g_inst
      localparam int N = (gi == 0) ? 1 : 3;

      mem_access_ctrl #(.ACCESS_CYCLES(N)) u_dut (
         .clk        (clk),
         .rst        (rst),
         .req_valid  (req_valid_a[gi]),
         .req_write  (req_write_a[gi]),
         .req_addr   (req_addr_a[gi]),
         .req_wdata  (req_wdata_a[gi]),
         .req_ready  (ready_a[gi]),
         .resp_valid (resp_valid_a[gi]),
         .resp_err   (resp_err_a[gi]),
         .resp_rdata (resp_rdata_a[gi]),
         .MemRead    (mem_read_a[gi]),
         .memWrite   (mem_write_a[gi]),
         .Address    (address_a[gi]),
         .write_data (write_data_a[gi]),
         .read_data  (read_data_a[gi])
      );

      // MEM: combinational read, write on the clock edge while memWrite is high
      bit [31:0] mem [64];
      bit [63:0] mem_wmask;
      assign read_data_a[gi] = mem_wmask[address_a[gi][7:2]] ? mem[address_a[gi][7:2]]
                                                             : init_word(address_a[gi][7:2]);
      always @(posedge clk) begin
         if (mem_write_a[gi]) begin
            mem[address_a[gi][7:2]]       <= write_data_a[gi];
            mem_wmask[address_a[gi][7:2]] <= 1'b1;
         end
      end

      // Reference model: a transaction timeline counted from the accept edge
      bit          act, mwr, mmis;
      int          st;
      logic [31:0] ea, ew, rexp;
      bit   [31:0] mm [64];
      bit   [63:0] mm_mask;

      function automatic bit m_ready();
         return !rst && (!act || (cyc - st) >= (mmis ? 2 : N + 3));
      endfunction

      always @(posedge clk) begin
         if (rst) begin
            act <= 1'b0;
            ea  <= 32'h0;
            ew  <= 32'h0;
         end else if (req_valid_a[gi] && m_ready()) begin
            act  <= 1'b1;
            st   <= cyc;
            mwr  <= req_write_a[gi];
            mmis <= (req_addr_a[gi][1:0] != 2'b00);
            if (req_addr_a[gi][1:0] == 2'b00) begin
               ea <= req_addr_a[gi];
               ew <= req_wdata_a[gi];
               if (req_write_a[gi]) begin
                  mm[req_addr_a[gi][7:2]]      <= req_wdata_a[gi];
                  mm_mask[req_addr_a[gi][7:2]] <= 1'b1;
               end else begin
                  rexp <= mm_mask[req_addr_a[gi][7:2]] ? mm[req_addr_a[gi][7:2]]
                                                       : init_word(req_addr_a[gi][7:2]);
               end
            end
         end
      end

      always @(negedge clk) begin : cmp
         int k;
         bit al, e_rd, e_wr, e_rv, e_er;
         logic [31:0] e_rdata;
         if (cmp_en) begin
            k       = cyc - st;
            al      = act && !mmis;
            e_rd    = al && !mwr && k >= 2 && k <= N + 1;
            e_wr    = al && mwr && k >= 2 && k <= N + 1;
            e_rv    = act && (mmis ? (k == 1) : (k == N + 2));
            e_er    = act && mmis && (k == 1);
            e_rdata = (e_rv && al && !mwr) ? rexp : 32'h0;
            check($sformatf("u%0d req_ready", gi),  32'(ready_a[gi]),      32'(m_ready()));
            check($sformatf("u%0d MemRead", gi),    32'(mem_read_a[gi]),   32'(e_rd));
            check($sformatf("u%0d memWrite", gi),   32'(mem_write_a[gi]),  32'(e_wr));
            check($sformatf("u%0d strobe_excl", gi), 32'(mem_read_a[gi] & mem_write_a[gi]), 32'h0);
            check($sformatf("u%0d Address", gi),    address_a[gi],         ea);
            check($sformatf("u%0d write_data", gi), write_data_a[gi],      ew);
            check($sformatf("u%0d resp_valid", gi), 32'(resp_valid_a[gi]), 32'(e_rv));
            check($sformatf("u%0d resp_err", gi),   32'(resp_err_a[gi]),   32'(e_er));
            check($sformatf("u%0d resp_rdata", gi), resp_rdata_a[gi],      e_rdata);
         end
      end
   end

   // Present one request, hold it until accepted; returns #1 after the accept edge
   task automatic send(input int i, input bit wr, input logic [31:0] a, input logic [31:0] d,
                       input bit keep, output int acc);
      bit done;
      done = 1'b0;
      acc  = -1;
      @(negedge clk);
      req_valid_a[i] = 1'b1;
      req_write_a[i] = wr;
      req_addr_a[i]  = a;
      req_wdata_a[i] = d;
      for (int t = 0; t < 40 && !done; t++) begin
         if (ready_a[i]) begin
            @(posedge clk);
            #1;
            acc  = cyc;
            done = 1'b1;
         end else begin
            @(negedge clk);
         end
      end
      if (!done) begin
         vectors++;
         miscompares++;
         $display("FAIL accept_timeout: u%0d request at %h never accepted", i, a);
      end
      if (!keep) req_valid_a[i] = 1'b0;
   endtask

   initial begin
      int a1, a2;
      for (int i = 0; i < 2; i++) begin
         req_valid_a[i] = 1'b0;
         req_write_a[i] = 1'b0;
         req_addr_a[i]  = 32'h0;
         req_wdata_a[i] = 32'h0;
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset req_ready", 32'(ready_a[0]), 32'h0);
      check("reset Address", address_a[0], 32'h0);
      @(posedge clk);
      #1 rst = 1'b0;

      // Store N=1: 0x10 <- DEADBEEF
      send(0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, a1);
      @(negedge clk);
      check("st setup Address", address_a[0], 32'h10);
      check("st setup memWrite", 32'(mem_write_a[0]), 32'h0);
      @(negedge clk);
      check("st strobe memWrite", 32'(mem_write_a[0]), 32'h1);
      check("st strobe write_data", write_data_a[0], 32'hDEADBEEF);
      @(negedge clk);
      check("st hold memWrite", 32'(mem_write_a[0]), 32'h0);
      check("st resp_valid", 32'(resp_valid_a[0]), 32'h1);
      check("st resp_rdata", resp_rdata_a[0], 32'h0);
      @(negedge clk);
      check("st ready back", 32'(ready_a[0]), 32'h1);

      // Load N=3 from 0x10 (MEM holds CAFEF00D)
      send(1, 1'b0, 32'h10, 32'h0, 1'b0, a1);
      @(negedge clk);
      check("ld setup MemRead", 32'(mem_read_a[1]), 32'h0);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("ld strobe MemRead", 32'(mem_read_a[1]), 32'h1);
      end
      @(negedge clk);
      check("ld resp_valid", 32'(resp_valid_a[1]), 32'h1);
      check("ld resp_rdata", resp_rdata_a[1], 32'hCAFEF00D);
      @(negedge clk);
      check("ld rdata cleared", resp_rdata_a[1], 32'h0);

      // Misaligned load at 0x13
      send(0, 1'b0, 32'h13, 32'h0, 1'b0, a1);
      @(negedge clk);
      check("mis resp_valid", 32'(resp_valid_a[0]), 32'h1);
      check("mis resp_err", 32'(resp_err_a[0]), 32'h1);
      check("mis MemRead", 32'(mem_read_a[0]), 32'h0);
      @(negedge clk);
      check("mis ready back", 32'(ready_a[0]), 32'h1);

      // Back-to-back store 0x20 <- 5 then load 0x20, req_valid held high
      send(0, 1'b1, 32'h20, 32'h5, 1'b1, a1);
      send(0, 1'b0, 32'h20, 32'h0, 1'b0, a2);
      check("b2b accept gap", 32'(a2 - a1), 32'd4);
      repeat (3) @(negedge clk);
      check("b2b ld resp_valid", 32'(resp_valid_a[0]), 32'h1);
      check("b2b ld rdata", resp_rdata_a[0], 32'h5);

      // Reset during STROBE of a store
      send(0, 1'b1, 32'h40, 32'h1234, 1'b0, a1);
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      check("rst pre memWrite", 32'(mem_write_a[0]), 32'h1);
      @(posedge clk);
      #1;
      @(negedge clk);
      check("rst memWrite", 32'(mem_write_a[0]), 32'h0);
      check("rst resp_valid", 32'(resp_valid_a[0]), 32'h0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst ready after", 32'(ready_a[0]), 32'h1);
      check("rst no resp", 32'(resp_valid_a[0]), 32'h0);
      send(0, 1'b0, 32'h0, 32'h0, 1'b0, a1);
      repeat (3) @(negedge clk);
      check("post-rst ld resp_valid", 32'(resp_valid_a[0]), 32'h1);
      check("post-rst ld rdata", resp_rdata_a[0], 32'h0);

      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
